ddr_burst_arbiter: RTL and testbench

- Sits directly downstream of the data cache, between it and the DDR native burst controller.
- Accepts level-held requests for data-block load, data-block store and jump-address load.
- Arbitrates them, issues one read or write burst at a time, and streams beats back to or from the cache.
- Publishes per-beat counters and its current state so the cache can index its line array.

---
 rtl/ddr_burst_arbiter_if.sv | 39 +++
 rtl/ddr_burst_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_arbiter_if.sv
// Burst bus between the cache-side arbiter and the DDR native burst controller.
// The arbiter is the master: it issues read/write bursts. The controller is the slave:
// it returns read beats, requests write beats and pulses finish.
interface ddr_burst_arbiter_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28
);
  logic                      rd_burst_req;
  logic [9:0]                rd_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic                      rd_burst_data_valid_mem;
  logic [DATA_WIDTH-1:0]     rd_burst_data_mem;
  logic                      rd_burst_finish;

  logic                      wr_burst_req;
  logic [9:0]                wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
  logic                      wr_burst_data_req_mem;
  logic [DATA_WIDTH-1:0]     wr_burst_data_mem;
  logic                      wr_burst_finish;

  modport master (
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid_mem, rd_burst_data_mem, rd_burst_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr,
    input  wr_burst_data_req_mem,
    output wr_burst_data_mem,
    input  wr_burst_finish
  );

  modport slave (
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid_mem, rd_burst_data_mem, rd_burst_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr,
    output wr_burst_data_req_mem,
    input  wr_burst_data_mem,
    output wr_burst_finish
  );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// Arbiter between the data cache and the DDR burst controller.
// Grants one of store / data read / jump read (in that priority), runs a single
// burst, streams beats to/from the cache and waits for the cache to drop the
// granted request before arbitrating again.
//
// state                | meaning
// ---------------------+--------------------------------------------------
// IDLE (0)             | arbitrate pending requests
// MEM_READ_DATA (6)    | data-block read burst in flight
// MEM_READ_JMP (7)     | jump-address read burst in flight
// MEM_WRITE_DATA_STORE (9) | data-block write burst in flight
// WAIT_RELEASE (10)    | burst done, wait for granted request to drop
module ddr_burst_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int RD_BURST_LEN   = 17,
  parameter int WR_BURST_LEN   = 16,
  parameter int JMP_BURST_LEN  = 1
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      DATA_read_req,
  input  logic                      DATA_store_req,
  input  logic                      JMP_ADDR_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  input  logic                      data_to_ddr_rdy,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
  output logic [9:0]                rd_cnt_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic [3:0]                state_interface_module,

  ddr_burst_arbiter_if.master       ddr
);

  typedef enum logic [3:0] {
    IDLE                 = 4'd0,
    MEM_READ_DATA        = 4'd6,
    MEM_READ_JMP         = 4'd7,
    MEM_WRITE_DATA_STORE = 4'd9,
    WAIT_RELEASE         = 4'd10
  } state_t;

  // Which request owns the current burst; WAIT_RELEASE watches only this one.
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_STORE = 2'd1,
    SRC_READ  = 2'd2,
    SRC_JMP   = 2'd3
  } src_t;

  state_t state;
  src_t   grant_src;
  logic   granted_req_high;

  // Level of the request that was granted, used to detect its release.
  always_comb begin
    granted_req_high = 1'b0;
    case (grant_src)
      SRC_STORE: granted_req_high = DATA_store_req;
      SRC_READ:  granted_req_high = DATA_read_req;
      SRC_JMP:   granted_req_high = JMP_ADDR_read_req;
      default:   granted_req_high = 1'b0;
    endcase
  end

  // Store beats pass straight through; a missing cache beat is sent as zero, no stall.
  assign wr_burst_data_req      = ddr.wr_burst_data_req_mem && (state == MEM_WRITE_DATA_STORE);
  assign ddr.wr_burst_data_mem  = data_to_ddr_rdy ? DATA_to_ddr : '0;
  assign state_interface_module = state;

  // Main FSM: arbitration, burst handshake, read-beat capture and release wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      grant_src           <= SRC_NONE;
      DATA_to_cache       <= '0;
      JMP_ADDR_to_cache   <= '0;
      rd_cnt_data         <= '0;
      rd_burst_data_valid <= 1'b0;
      ddr.rd_burst_req    <= 1'b0;
      ddr.rd_burst_len    <= '0;
      ddr.rd_burst_addr   <= '0;
      ddr.wr_burst_req    <= 1'b0;
      ddr.wr_burst_len    <= '0;
      ddr.wr_burst_addr   <= '0;
    end else begin
      rd_burst_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (DATA_store_req) begin
            ddr.wr_burst_addr <= DATA_write_addr;
            ddr.wr_burst_len  <= 10'(WR_BURST_LEN);
            ddr.wr_burst_req  <= 1'b1;
            rd_cnt_data       <= '0;
            grant_src         <= SRC_STORE;
            state             <= MEM_WRITE_DATA_STORE;
          end else if (DATA_read_req) begin
            ddr.rd_burst_addr <= DATA_read_addr;
            ddr.rd_burst_len  <= 10'(RD_BURST_LEN);
            ddr.rd_burst_req  <= 1'b1;
            rd_cnt_data       <= '0;
            grant_src         <= SRC_READ;
            state             <= MEM_READ_DATA;
          end else if (JMP_ADDR_read_req) begin
            ddr.rd_burst_addr <= DATA_read_addr;
            ddr.rd_burst_len  <= 10'(JMP_BURST_LEN);
            ddr.rd_burst_req  <= 1'b1;
            rd_cnt_data       <= '0;
            grant_src         <= SRC_JMP;
            state             <= MEM_READ_JMP;
          end
        end

        MEM_READ_DATA, MEM_READ_JMP: begin
          // A beat arriving with the finish pulse is still captured and counted.
          if (ddr.rd_burst_data_valid_mem) begin
            DATA_to_cache       <= ddr.rd_burst_data_mem;
            rd_burst_data_valid <= 1'b1;
            if (rd_cnt_data != 10'h3FF) begin
              rd_cnt_data <= rd_cnt_data + 10'd1;
            end
            // Jump address is carried by the first beat of the jump burst.
            if (state == MEM_READ_JMP && rd_cnt_data == 10'd0) begin
              JMP_ADDR_to_cache <= DDR_ADDR_WIDTH'(ddr.rd_burst_data_mem);
            end
          end
          if (ddr.rd_burst_finish) begin
            ddr.rd_burst_req <= 1'b0;
            state            <= WAIT_RELEASE;
          end
        end

        MEM_WRITE_DATA_STORE: begin
          if (ddr.wr_burst_finish) begin
            ddr.wr_burst_req <= 1'b0;
            state            <= WAIT_RELEASE;
          end
        end

        WAIT_RELEASE: begin
          if (!granted_req_high) begin
            rd_cnt_data <= '0;
            grant_src   <= SRC_NONE;
            state       <= IDLE;
          end
        end

        default: begin
          ddr.rd_burst_req <= 1'b0;
          ddr.wr_burst_req <= 1'b0;
          grant_src        <= SRC_NONE;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter: the bench plays cache and DDR controller.
module tb_ddr_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        DATA_read_req, DATA_store_req, JMP_ADDR_read_req;
  logic [27:0] DATA_read_addr, DATA_write_addr;
  logic [15:0] DATA_to_ddr;
  logic        data_to_ddr_rdy;
  logic [15:0] DATA_to_cache;
  logic [27:0] JMP_ADDR_to_cache;
  logic [9:0]  rd_cnt_data;
  logic        rd_burst_data_valid;
  logic        wr_burst_data_req;
  logic [3:0]  state_interface_module;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_burst_arbiter_if #(.DATA_WIDTH(16), .DDR_ADDR_WIDTH(28)) bus ();

  ddr_burst_arbiter dut (
    .clk                    (clk),
    .rst                    (rst),
    .DATA_read_req          (DATA_read_req),
    .DATA_store_req         (DATA_store_req),
    .JMP_ADDR_read_req      (JMP_ADDR_read_req),
    .DATA_read_addr         (DATA_read_addr),
    .DATA_write_addr        (DATA_write_addr),
    .DATA_to_ddr            (DATA_to_ddr),
    .data_to_ddr_rdy        (data_to_ddr_rdy),
    .DATA_to_cache          (DATA_to_cache),
    .JMP_ADDR_to_cache      (JMP_ADDR_to_cache),
    .rd_cnt_data            (rd_cnt_data),
    .rd_burst_data_valid    (rd_burst_data_valid),
    .wr_burst_data_req      (wr_burst_data_req),
    .state_interface_module (state_interface_module),
    .ddr                    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller returns n read beats base..base+n-1; optionally finish rides the last beat.
  task automatic read_beats(input int n, input logic [15:0] base, input bit fin_last);
    for (int i = 0; i < n; i++) begin
      bus.rd_burst_data_valid_mem = 1'b1;
      bus.rd_burst_data_mem       = base + 16'(i);
      bus.rd_burst_finish         = fin_last && (i == n - 1);
      tick();
      chk("rd_cnt", 32'(rd_cnt_data), 32'(i + 1));
      chk("data_to_cache", 32'(DATA_to_cache), 32'(base + 16'(i)));
      chk("rd_valid", 32'(rd_burst_data_valid), 32'd1);
    end
    bus.rd_burst_data_valid_mem = 1'b0;
    bus.rd_burst_finish         = 1'b0;
    if (fin_last) chk("state_after_fin_beat", 32'(state_interface_module), 32'd10);
  endtask

  task automatic rd_finish();
    bus.rd_burst_finish = 1'b1;
    tick();
    bus.rd_burst_finish = 1'b0;
  endtask

  task automatic wr_finish();
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    DATA_read_req = 0; DATA_store_req = 0; JMP_ADDR_read_req = 0;
    DATA_read_addr = '0; DATA_write_addr = '0; DATA_to_ddr = '0; data_to_ddr_rdy = 0;
    bus.rd_burst_data_valid_mem = 0; bus.rd_burst_data_mem = '0; bus.rd_burst_finish = 0;
    bus.wr_burst_data_req_mem = 0; bus.wr_burst_finish = 0;
    repeat (2) tick();
    chk("rst_state", 32'(state_interface_module), 32'd0);
    chk("rst_rd_req", 32'(bus.rd_burst_req), 32'd0);
    chk("rst_wr_req", 32'(bus.wr_burst_req), 32'd0);
    chk("rst_rd_cnt", 32'(rd_cnt_data), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_state", 32'(state_interface_module), 32'd0);

    // Data read, 17 beats, separate finish
    DATA_read_addr = 28'h400; DATA_read_req = 1;
    tick();
    chk("rd_state", 32'(state_interface_module), 32'd6);
    chk("rd_req", 32'(bus.rd_burst_req), 32'd1);
    chk("rd_addr", 32'(bus.rd_burst_addr), 32'h400);
    chk("rd_len", 32'(bus.rd_burst_len), 32'd17);
    chk("rd_cnt_start", 32'(rd_cnt_data), 32'd0);
    read_beats(17, 16'h0000, 1'b0);
    rd_finish();
    chk("rd_fin_state", 32'(state_interface_module), 32'd10);
    chk("rd_fin_req", 32'(bus.rd_burst_req), 32'd0);
    chk("rd_fin_cnt", 32'(rd_cnt_data), 32'd17);
    chk("rd_fin_valid", 32'(rd_burst_data_valid), 32'd0);
    tick();
    chk("wait_hold", 32'(state_interface_module), 32'd10);
    DATA_read_req = 0;
    tick();
    chk("rel_state", 32'(state_interface_module), 32'd0);
    chk("rel_cnt", 32'(rd_cnt_data), 32'd0);
    bus.rd_burst_finish = 1; bus.wr_burst_finish = 1;
    tick();
    bus.rd_burst_finish = 0; bus.wr_burst_finish = 0;
    chk("stray_fin_state", 32'(state_interface_module), 32'd0);

    // Jump read
    DATA_read_addr = 28'h123; JMP_ADDR_read_req = 1;
    tick();
    chk("jmp_state", 32'(state_interface_module), 32'd7);
    chk("jmp_len", 32'(bus.rd_burst_len), 32'd1);
    chk("jmp_addr", 32'(bus.rd_burst_addr), 32'h123);
    read_beats(1, 16'hBEEF, 1'b0);
    chk("jmp_addr_to_cache", 32'(JMP_ADDR_to_cache), 32'h000BEEF);
    rd_finish();
    chk("jmp_fin_state", 32'(state_interface_module), 32'd10);
    JMP_ADDR_read_req = 0;
    tick();
    chk("jmp_rel", 32'(state_interface_module), 32'd0);

    // Store, 16 beats
    DATA_write_addr = 28'h28000; DATA_store_req = 1; data_to_ddr_rdy = 1;
    tick();
    chk("wr_state", 32'(state_interface_module), 32'd9);
    chk("wr_req", 32'(bus.wr_burst_req), 32'd1);
    chk("wr_len", 32'(bus.wr_burst_len), 32'd16);
    chk("wr_addr", 32'(bus.wr_burst_addr), 32'h28000);
    for (int n = 0; n < 16; n++) begin
      bus.wr_burst_data_req_mem = 1; DATA_to_ddr = 16'hA000 + 16'(n);
      #1;
      chk("wr_data_req", 32'(wr_burst_data_req), 32'd1);
      chk("wr_data", 32'(bus.wr_burst_data_mem), 32'hA000 + 32'(n));
      tick();
    end
    data_to_ddr_rdy = 0;
    #1;
    chk("wr_data_not_rdy", 32'(bus.wr_burst_data_mem), 32'd0);
    bus.wr_burst_data_req_mem = 0; data_to_ddr_rdy = 1;
    wr_finish();
    chk("wr_fin_state", 32'(state_interface_module), 32'd10);
    chk("wr_fin_req", 32'(bus.wr_burst_req), 32'd0);
    bus.wr_burst_data_req_mem = 1;
    #1;
    chk("wr_req_gated", 32'(wr_burst_data_req), 32'd0);
    bus.wr_burst_data_req_mem = 0;
    DATA_store_req = 0;
    tick();
    chk("wr_rel", 32'(state_interface_module), 32'd0);

    // Priority: all three at once
    DATA_store_req = 1; DATA_read_req = 1; JMP_ADDR_read_req = 1;
    tick();
    chk("prio_store", 32'(state_interface_module), 32'd9);
    wr_finish();
    tick();
    chk("prio_wait_others", 32'(state_interface_module), 32'd10);
    DATA_store_req = 0;
    tick();
    chk("prio_idle1", 32'(state_interface_module), 32'd0);
    tick();
    chk("prio_read", 32'(state_interface_module), 32'd6);
    rd_finish();
    DATA_read_req = 0;
    tick();
    chk("prio_idle2", 32'(state_interface_module), 32'd0);
    tick();
    chk("prio_jmp", 32'(state_interface_module), 32'd7);
    rd_finish();
    JMP_ADDR_read_req = 0;
    tick();
    chk("prio_idle3", 32'(state_interface_module), 32'd0);

    // Reset mid read burst at beat 5
    DATA_read_addr = 28'h800; DATA_read_req = 1;
    tick();
    read_beats(5, 16'h0050, 1'b0);
    rst = 0;
    #1;
    chk("mid_rst_state", 32'(state_interface_module), 32'd0);
    chk("mid_rst_cnt", 32'(rd_cnt_data), 32'd0);
    chk("mid_rst_data", 32'(DATA_to_cache), 32'd0);
    chk("mid_rst_req", 32'(bus.rd_burst_req), 32'd0);
    chk("mid_rst_addr", 32'(bus.rd_burst_addr), 32'd0);
    chk("mid_rst_len", 32'(bus.rd_burst_len), 32'd0);
    chk("mid_rst_jmp", 32'(JMP_ADDR_to_cache), 32'd0);
    rst = 1;
    tick();
    chk("post_rst_state", 32'(state_interface_module), 32'd6);
    chk("post_rst_cnt", 32'(rd_cnt_data), 32'd0);

    // Finish coincident with the 17th beat
    read_beats(17, 16'h0100, 1'b1);
    chk("coinc_cnt", 32'(rd_cnt_data), 32'd17);
    chk("coinc_data", 32'(DATA_to_cache), 32'h0110);
    chk("coinc_req", 32'(bus.rd_burst_req), 32'd0);
    DATA_read_req = 0;
    tick();
    chk("coinc_rel", 32'(state_interface_module), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
